// File: rtl/rf_seq_pkg.sv
// Shared opcodes, FSM state encoding and status-flag bit positions for the RF
// operation sequencer.
package rf_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_MOV = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam int FLAG_W = 5;
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_CMP;
   endfunction

   // Every legal opcode below CMP produces a register result.
   function automatic logic op_writes_back(input logic [3:0] op);
      return op < OP_CMP;
   endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the RF sequencer: result, candidate flag values and a
// mask selecting which status flags the operation is allowed to change.
module rf_seq_alu
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result,
   output logic [FLAG_W-1:0] flags_nxt,
   output logic [FLAG_W-1:0] flags_mask
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   always_comb begin
      sum        = {1'b0, a} + {1'b0, b};
      diff       = {1'b0, a} - {1'b0, b};
      result     = '0;
      flags_nxt  = '0;
      flags_mask = '0;
      case (op)
         OP_ADD: begin
            result            = sum[MSB:0];
            flags_nxt[FLAG_C] = sum[DATA_W];
            flags_nxt[FLAG_F] = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            flags_mask[FLAG_C] = 1'b1;
            flags_mask[FLAG_F] = 1'b1;
         end
         OP_SUB: begin
            // The extra top bit of the widened difference is the unsigned borrow.
            result            = diff[MSB:0];
            flags_nxt[FLAG_C] = diff[DATA_W];
            flags_nxt[FLAG_F] = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            flags_mask[FLAG_C] = 1'b1;
            flags_mask[FLAG_F] = 1'b1;
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_MOV: result = b;
         OP_CMP: begin
            result            = diff[MSB:0];
            flags_nxt[FLAG_Z] = (a == b);
            flags_nxt[FLAG_L] = diff[DATA_W];
            flags_nxt[FLAG_N] = ($signed(a) < $signed(b));
            flags_mask[FLAG_Z] = 1'b1;
            flags_mask[FLAG_L] = 1'b1;
            flags_mask[FLAG_N] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rf_op_sequencer.sv
// Multi-cycle controller driving the RF port interface: one reg/imm operation
// per handshake, operand read, ALU execute, optional write-back, status flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | req_ready high, latch request on handshake
//   S_READ  | drive RF read addresses, capture operands A and B
//   S_EXEC  | register ALU result, update flags, pick write-back or done
//   S_WRITE | one-cycle RF write of the result to rdest
module rf_op_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_rdest,
   input  logic [ADDR_W-1:0] req_rsrc,
   input  logic [DATA_W-1:0] req_imm,
   input  logic              req_use_imm,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   output logic              rf_wr_en,
   output logic [DATA_W-1:0] rf_wr_data,
   input  logic [DATA_W-1:0] rf_rd_data1,
   input  logic [DATA_W-1:0] rf_rd_data2,
   output logic [4:0]        flags,
   output logic              done,
   output logic              err
);

   state_t              state_q,   state_d;
   logic [3:0]          op_q,      op_d;
   logic [ADDR_W-1:0]   rdest_q,   rdest_d;
   logic [ADDR_W-1:0]   rsrc_q,    rsrc_d;
   logic [DATA_W-1:0]   imm_q,     imm_d;
   logic                use_imm_q, use_imm_d;
   logic [DATA_W-1:0]   a_q,       a_d;
   logic [DATA_W-1:0]   b_q,       b_d;
   logic [DATA_W-1:0]   result_q,  result_d;
   logic [FLAG_W-1:0]   flags_q,   flags_d;
   logic                done_q,    done_d;
   logic                err_q,     err_d;

   logic [DATA_W-1:0]   alu_result;
   logic [FLAG_W-1:0]   alu_flags_nxt;
   logic [FLAG_W-1:0]   alu_flags_mask;
   logic                wr_en_raw;

   rf_seq_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a          (a_q),
      .b          (b_q),
      .op         (op_q),
      .result     (alu_result),
      .flags_nxt  (alu_flags_nxt),
      .flags_mask (alu_flags_mask)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rdest_d    = rdest_q;
      rsrc_d     = rsrc_q;
      imm_d      = imm_q;
      use_imm_d  = use_imm_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      flags_d    = flags_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      req_ready  = 1'b0;
      rf_addr1   = '0;
      rf_addr2   = '0;
      rf_wr_data = '0;
      wr_en_raw  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d      = req_op;
               rdest_d   = req_rdest;
               rsrc_d    = req_rsrc;
               imm_d     = req_imm;
               use_imm_d = req_use_imm;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            rf_addr1 = rdest_q;
            rf_addr2 = rsrc_q;
            a_d      = rf_rd_data1;
            b_d      = use_imm_q ? imm_q : rf_rd_data2;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            // An illegal opcode yields an all-zero mask, so flags hold.
            result_d = alu_result;
            flags_d  = (flags_q & ~alu_flags_mask) | (alu_flags_nxt & alu_flags_mask);
            if (op_writes_back(op_q)) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = !op_is_legal(op_q);
            end
         end
         S_WRITE: begin
            rf_addr1   = rdest_q;
            rf_wr_data = result_q;
            wr_en_raw  = 1'b1;
            state_d    = S_IDLE;
            done_d     = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A reset landing on the WRITE cycle must not commit the RF write.
   assign rf_wr_en = wr_en_raw & ~reset;
   assign flags    = flags_q;
   assign done     = done_q;
   assign err      = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         rdest_q   <= '0;
         rsrc_q    <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rdest_q   <= rdest_d;
         rsrc_q    <= rsrc_d;
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

endmodule
